// File: rtl/avalon_mem_if_pkg.sv
// Shared command type for the registered Avalon-MM stage.
// Field widths match the default parameters of avalon_mem_if_skid_reg.
package avalon_mem_if_pkg;

  localparam int AVMM_ADDR_WIDTH      = 27;
  localparam int AVMM_DATA_WIDTH      = 512;
  localparam int AVMM_BURST_CNT_WIDTH = 7;
  localparam int AVMM_BE_WIDTH        = AVMM_DATA_WIDTH / 8;

  typedef struct packed {
    logic                            rd;
    logic                            wr;
    logic [AVMM_ADDR_WIDTH-1:0]      addr;
    logic [AVMM_BURST_CNT_WIDTH-1:0] burstcount;
    logic [AVMM_DATA_WIDTH-1:0]      writedata;
    logic [AVMM_BE_WIDTH-1:0]        byteenable;
  } t_avmm_cmd;

endpackage

// File: rtl/avalon_mem_cmd_skid.sv
// Two-entry main/skid register pair. in_ready is a flop, so the producer sees
// backpressure one cycle late; the skid entry catches the beat that lands meanwhile.
module avalon_mem_cmd_skid
  import avalon_mem_if_pkg::*;
(
  input  logic      clk,
  input  logic      reset,
  input  logic      in_valid,
  output logic      in_ready,
  input  t_avmm_cmd in_data,
  output logic      out_valid,
  input  logic      out_ready,
  output t_avmm_cmd out_data
);

  logic      m_valid, s_valid, ready_q;
  t_avmm_cmd m_data, s_data;
  logic      m_valid_nx, s_valid_nx;
  t_avmm_cmd m_data_nx, s_data_nx;
  logic      accept, consume;

  assign accept  = in_valid && ready_q;
  assign consume = m_valid && out_ready;

  always_comb begin
    m_valid_nx = m_valid;
    s_valid_nx = s_valid;
    m_data_nx  = m_data;
    s_data_nx  = s_data;
    if (!m_valid || consume) begin
      if (s_valid) begin
        m_valid_nx = 1'b1;
        m_data_nx  = s_data;
        s_valid_nx = accept;
        if (accept) s_data_nx = in_data;
      end else begin
        m_valid_nx = accept;
        if (accept) m_data_nx = in_data;
      end
    end else if (accept) begin
      s_valid_nx = 1'b1;
      s_data_nx  = in_data;
    end
  end

  // ready_q stays low through reset so the producer is held off until the cycle after release
  always_ff @(posedge clk) begin
    if (reset) begin
      m_valid <= 1'b0;
      s_valid <= 1'b0;
      ready_q <= 1'b0;
    end else begin
      m_valid <= m_valid_nx;
      s_valid <= s_valid_nx;
      ready_q <= !s_valid_nx;
    end
  end

  always_ff @(posedge clk) begin
    m_data <= m_data_nx;
    s_data <= s_data_nx;
  end

  assign in_ready  = ready_q;
  assign out_valid = m_valid;
  assign out_data  = m_data;

endmodule

// File: rtl/avalon_mem_if_skid_reg.sv
// One registered Avalon-MM pipeline stage honouring waitrequest: command path through a
// 2-entry skid, read response delayed one cycle with no backpressure.
module avalon_mem_if_skid_reg
  import avalon_mem_if_pkg::*;
#(
  parameter int ADDR_WIDTH      = AVMM_ADDR_WIDTH,
  parameter int DATA_WIDTH      = AVMM_DATA_WIDTH,
  parameter int BURST_CNT_WIDTH = AVMM_BURST_CNT_WIDTH
) (
  input  logic                       clk,
  input  logic                       reset,

  input  logic [ADDR_WIDTH-1:0]      afu_address,
  input  logic [BURST_CNT_WIDTH-1:0] afu_burstcount,
  input  logic [DATA_WIDTH-1:0]      afu_writedata,
  input  logic [DATA_WIDTH/8-1:0]    afu_byteenable,
  input  logic                       afu_read,
  input  logic                       afu_write,
  output logic                       afu_waitrequest,
  output logic [DATA_WIDTH-1:0]      afu_readdata,
  output logic                       afu_readdatavalid,

  output logic [ADDR_WIDTH-1:0]      fiu_address,
  output logic [BURST_CNT_WIDTH-1:0] fiu_burstcount,
  output logic [DATA_WIDTH-1:0]      fiu_writedata,
  output logic [DATA_WIDTH/8-1:0]    fiu_byteenable,
  output logic                       fiu_read,
  output logic                       fiu_write,
  input  logic                       fiu_waitrequest,
  input  logic [DATA_WIDTH-1:0]      fiu_readdata,
  input  logic                       fiu_readdatavalid
);

  t_avmm_cmd cmd_in, cmd_out;
  logic      in_ready, out_valid;

  assign cmd_in = '{rd:         afu_read,
                    wr:         afu_write,
                    addr:       afu_address,
                    burstcount: afu_burstcount,
                    writedata:  afu_writedata,
                    byteenable: afu_byteenable};

  avalon_mem_cmd_skid u_skid (
    .clk       (clk),
    .reset     (reset),
    .in_valid  (afu_read || afu_write),
    .in_ready  (in_ready),
    .in_data   (cmd_in),
    .out_valid (out_valid),
    .out_ready (!fiu_waitrequest),
    .out_data  (cmd_out)
  );

  assign afu_waitrequest = !in_ready;
  assign fiu_read        = out_valid && cmd_out.rd;
  assign fiu_write       = out_valid && cmd_out.wr;
  assign fiu_address     = cmd_out.addr;
  assign fiu_burstcount  = cmd_out.burstcount;
  assign fiu_writedata   = cmd_out.writedata;
  assign fiu_byteenable  = cmd_out.byteenable;

  always_ff @(posedge clk) begin
    if (reset) afu_readdatavalid <= 1'b0;
    else       afu_readdatavalid <= fiu_readdatavalid;
  end

  // read data is not qualified, so it needs no reset
  always_ff @(posedge clk) begin
    afu_readdata <= fiu_readdata;
  end

  a_rd_wr_exclusive: assert property (@(posedge clk) disable iff (reset)
    !(afu_read && afu_write));

  a_cmd_held_while_waiting: assert property (@(posedge clk) disable iff (reset)
    ((afu_read || afu_write) && afu_waitrequest) |=>
      ($stable(afu_read) && $stable(afu_write) && $stable(afu_address) &&
       $stable(afu_burstcount) && $stable(afu_writedata) && $stable(afu_byteenable)));

endmodule
